// File: rtl/alarm_pkg.sv
// Shared encodings, BCD limits and defaults for the alarm controller.
// The snooze feature is enabled by defining ALARM_SNOOZE_EN (see alarm_ctrl.sv).
package alarm_pkg;

    localparam logic [1:0] MODE_RUN       = 2'd0;
    localparam logic [1:0] MODE_SET_TIME  = 2'd1;
    localparam logic [1:0] MODE_SET_ALARM = 2'd2;

    localparam logic [1:0] RS_IDLE   = 2'd0;
    localparam logic [1:0] RS_RING   = 2'd1;
    localparam logic [1:0] RS_SNOOZE = 2'd2;

    localparam logic [3:0] BCD_UNIT_MAX     = 4'd9;
    localparam logic [3:0] BCD_MIN_TENS_MAX = 4'd5;
    localparam logic [3:0] BCD_HR_TENS_MAX  = 4'd2;
    localparam logic [3:0] BCD_HR_UNIT_MAX  = 4'd3;

    localparam int DEF_RING_SECS   = 60;
    localparam int DEF_SNOOZE_SECS = 300;
    localparam int CNT_W           = 9;

    // Button slots in the rise vector.
    localparam int B_M   = 0;
    localparam int B_H   = 1;
    localparam int B_A   = 2;
    localparam int B_S   = 3;
    localparam int B_O   = 4;
    localparam int NUM_B = 5;

    // {tens, units} minutes, wraps 59 -> 00
    function automatic logic [7:0] bcd_inc_min(input logic [7:0] v);
        logic [7:0] r;
        r = v;
        if (v[3:0] == BCD_UNIT_MAX) begin
            r[3:0] = 4'd0;
            r[7:4] = (v[7:4] == BCD_MIN_TENS_MAX) ? 4'd0 : v[7:4] + 4'd1;
        end else begin
            r[3:0] = v[3:0] + 4'd1;
        end
        return r;
    endfunction

    // {tens, units} hours, wraps 23 -> 00
    function automatic logic [7:0] bcd_inc_hr(input logic [7:0] v);
        logic [7:0] r;
        r = v;
        if (v[7:4] == BCD_HR_TENS_MAX && v[3:0] == BCD_HR_UNIT_MAX) begin
            r = 8'h00;
        end else if (v[3:0] == BCD_UNIT_MAX) begin
            r[3:0] = 4'd0;
            r[7:4] = v[7:4] + 4'd1;
        end else begin
            r[3:0] = v[3:0] + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchronizer plus registered rising-edge pulse for one button.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic s1, s2, s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Synchronizer keeps sampling and history is forced high, so a
            // button held through reset yields no edge once reset drops.
            s1   <= btn;
            s2   <= s1;
            s3   <= 1'b1;
            rise <= 1'b0;
        end else begin
            s1   <= btn;
            s2   <= s1;
            s3   <= s2;
            rise <= s2 & ~s3;
        end
    end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm clock controller: mode FSM, BCD alarm setting, ring/snooze FSM.
// Define ALARM_SNOOZE_EN to enable the SNOOZE state.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int RING_SECS   = DEF_RING_SECS,
    parameter int SNOOZE_SECS = DEF_SNOOZE_SECS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_tick,
    input  logic       bm,
    input  logic       bh,
    input  logic       balam,
    input  logic       bset,
    input  logic       boff,
    input  logic [3:0] t0,
    input  logic [3:0] t1,
    input  logic [3:0] t2,
    input  logic [3:0] t3,
    output logic [3:0] al0,
    output logic [3:0] al1,
    output logic [3:0] al2,
    output logic [3:0] al3,
    output logic       inc_tm,
    output logic       inc_th,
    output logic [1:0] mode,
    output logic       alarm_en,
    output logic       ring
);

    localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_SECS - 1);
    localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_SECS - 1);

    logic [NUM_B-1:0] raw, rise;
    logic [1:0]       rstate, rnext;
    logic [CNT_W-1:0] cnt;
    logic             match, match_d, en_d, sec_done;

    assign raw = {boff, bset, balam, bh, bm};

    for (genvar i = 0; i < NUM_B; i++) begin : g_btn
        btn_edge u_btn (.clk(clk), .rst(rst), .btn(raw[i]), .rise(rise[i]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode <= MODE_RUN;
        end else begin
            case (mode)
                MODE_RUN:       if (rise[B_A]) mode <= MODE_SET_ALARM;
                                else if (rise[B_S]) mode <= MODE_SET_TIME;
                MODE_SET_ALARM: if (rise[B_A]) mode <= MODE_RUN;
                MODE_SET_TIME:  if (rise[B_S]) mode <= MODE_RUN;
                default:        mode <= MODE_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {al3, al2, al1, al0} <= 16'h0000;
        end else if (mode == MODE_SET_ALARM) begin
            if (rise[B_M])      {al1, al0} <= bcd_inc_min({al1, al0});
            else if (rise[B_H]) {al3, al2} <= bcd_inc_hr({al3, al2});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inc_tm   <= 1'b0;
            inc_th   <= 1'b0;
            alarm_en <= 1'b0;
            en_d     <= 1'b0;
            match_d  <= 1'b0;
        end else begin
            inc_tm  <= (mode == MODE_SET_TIME) & rise[B_M];
            inc_th  <= (mode == MODE_SET_TIME) & rise[B_H] & ~rise[B_M];
            if (mode == MODE_RUN && rstate == RS_IDLE && rise[B_O])
                alarm_en <= ~alarm_en;
            en_d    <= alarm_en;
            match_d <= match;
        end
    end

    assign match    = ({t3, t2, t1, t0} == {al3, al2, al1, al0});
    assign sec_done = sec_tick && (cnt == ((rstate == RS_SNOOZE) ? SNOOZE_LAST : RING_LAST));

    always_comb begin
        rnext = rstate;
        if (mode != MODE_RUN || (en_d && !alarm_en)) begin
            rnext = RS_IDLE;
        end else begin
            case (rstate)
                RS_IDLE: if (alarm_en && match && !match_d) rnext = RS_RING;
                RS_RING: begin
                    if (rise[B_O] || sec_done) rnext = RS_IDLE;
`ifdef ALARM_SNOOZE_EN
                    else if (rise[B_M])        rnext = RS_SNOOZE;
`endif
                end
`ifdef ALARM_SNOOZE_EN
                RS_SNOOZE: begin
                    if (rise[B_O])     rnext = RS_IDLE;
                    else if (sec_done) rnext = RS_RING;
                end
`endif
                default: rnext = RS_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rstate <= RS_IDLE;
            cnt    <= '0;
        end else begin
            rstate <= rnext;
            if (rnext != rstate)                      cnt <= '0;
            else if (sec_tick && rstate != RS_IDLE) cnt <= cnt + 1'b1;
        end
    end

    assign ring = (rstate == RS_RING);

endmodule
